// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel -- four-requester round-robin arbiter producing the select for a
// downstream 4:1 mux.
//
// One requester owns the mux at a time. Ownership ends on a done pulse, when
// the owner drops its request, or when the optional hold timer expires. The
// releasing owner becomes lowest priority for the next arbitration, and at
// least one idle cycle separates consecutive owners.
//
// Parameters:
//   MAX_HOLD  maximum cycles a grant may be held (0 disables the timer, 0..255)
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   [3:0] level-sensitive request per requester
//   done     in   release pulse from the current owner (ignored while idle)
//   grant    out  [3:0] one-hot grant, zero while idle
//   sel      out  [1:0] owner index; keeps the last owner while idle
//   busy     out  high while a grant is active
//   timeout  out  one-cycle pulse when the hold timer alone ends a grant
//
// Handshake: a requester holds req[i] high until it sees grant[i]; it keeps
// req[i] high for as long as it wants ownership and ends it either with a
// one-cycle done pulse or by dropping req[i]. The grant falls on the edge
// that observes either of those.
module rr_arb4_sel #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Hold counter wide enough to represent MAX_HOLD, never narrower than 1 bit.
  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] hold_cnt;

  // Winner search: first set request at or above ptr, wrapping 3 -> 0.
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_found;

  always_comb begin
    scan_idx  = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Release causes, evaluated only while a grant is active.
  logic rel_done;
  logic rel_drop;
  logic rel_hold;
  logic rel_any;

  always_comb begin
    rel_done = done;
    rel_drop = ~req[sel];
    rel_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    rel_any  = rel_done | rel_drop | rel_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_found) begin
            state    <= OWN;
            grant    <= 4'(1) << win_idx;
            sel      <= win_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (rel_any) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            // Owner drops to lowest priority; sel keeps pointing at it.
            ptr     <= sel + 2'd1;
            // Flag only releases caused by the timer and nothing else.
            timeout <= rel_hold & ~rel_done & ~rel_drop;
          end else begin
            timeout <= 1'b0;
            // With the timer disabled the counter stays parked at zero.
            if (MAX_HOLD != 0) begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Testbench for rr_arb4_sel with MAX_HOLD = 4. Directed scenarios check fixed
// expected values; a randomized run checks against an ownership-level model.
module tb_rr_arb4_sel;

  localparam int K = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arb4_sel #(.MAX_HOLD(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Owner is an integer (-1 when idle); held counts completed owned cycles.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_held;
  bit m_timeout;

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 0;
    m_ptr     = 0;
    m_held    = 0;
    m_timeout = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    bit by_done, by_drop, by_time;
    if (m_owner < 0) begin
      m_timeout = 0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
          m_last  = i;
          m_held  = 0;
        end
      end
    end else begin
      by_done = d;
      by_drop = !r[m_owner];
      by_time = (K != 0) && (m_held + 1 == K);
      if (by_done || by_drop || by_time) begin
        m_timeout = by_time && !by_done && !by_drop;
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = -1;
      end else begin
        m_timeout = 0;
        m_held++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge(req, done);
    #1;
  endtask

  task automatic do_reset();
    req  = '0;
    done = 1'b0;
    rst  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", sel); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    n_checks++; if (grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", grant); else n_pass++;
    n_checks++; if (sel !== 2'd2) $display("FAIL single_sel got %0d want 2", sel); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++; if (grant !== 4'b0000) $display("FAIL single_rel_grant got %b want 0000", grant); else n_pass++;
    n_checks++; if (sel !== 2'd2) $display("FAIL single_rel_sel got %0d want 2", sel); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_rel_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL single_rel_timeout got %b want 0", timeout); else n_pass++;
    // done while idle must not do anything
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_done_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++; if (grant !== 4'(1 << order[n])) $display("FAIL rot_grant[%0d] got %b want %b", n, grant, 4'(1 << order[n])); else n_pass++;
      n_checks++; if (sel !== 2'(order[n])) $display("FAIL rot_sel[%0d] got %0d want %0d", n, sel, order[n]); else n_pass++;
      tick();
      n_checks++; if (grant !== 4'(1 << order[n])) $display("FAIL rot_hold[%0d] got %b want %b", n, grant, 4'(1 << order[n])); else n_pass++;
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++; if (grant !== 4'b0000) $display("FAIL rot_idle[%0d] got %b want 0000", n, grant); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'b0001) $display("FAIL to_grant0 got %b want 0001", grant); else n_pass++;
    for (int c = 1; c < K; c++) begin
      tick();
      n_checks++; if (grant !== 4'b0001 || timeout !== 1'b0) $display("FAIL to_hold[%0d] got grant=%b timeout=%b want 0001/0", c, grant, timeout); else n_pass++;
    end
    tick();
    n_checks++; if (grant !== 4'b0000) $display("FAIL to_release got %b want 0000", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b1) $display("FAIL to_pulse got %b want 1", timeout); else n_pass++;
    tick();
    n_checks++; if (grant !== 4'b0001) $display("FAIL to_regrant got %b want 0001", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL to_pulse_end got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c < K; c++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++; if (grant !== 4'b0000) $display("FAIL sim_release got %b want 0000", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL sim_timeout got %b want 0", timeout); else n_pass++;
    // implicit release by dropping req, then check the pointer moved past owner 0
    do_reset();
    req = 4'b0011;
    tick();
    n_checks++; if (grant !== 4'b0001) $display("FAIL drop_grant got %b want 0001", grant); else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++; if (grant !== 4'b0000) $display("FAIL drop_release got %b want 0000", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL drop_timeout got %b want 0", timeout); else n_pass++;
    req = 4'b0011;
    tick();
    n_checks++; if (grant !== 4'b0010) $display("FAIL drop_ptr got %b want 0010", grant); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    tick();
    n_checks++; if (sel !== 2'd3) $display("FAIL wrap_owner got %0d want 3", sel); else n_pass++;
    req  = 4'b1001;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0001) $display("FAIL wrap_grant got %b want 0001", grant); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL wrap_sel got %0d want 0", sel); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    tick();
    n_checks++; if (grant !== 4'b1000) $display("FAIL ar_pre got %b want 1000", grant); else n_pass++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (grant !== 4'b0000) $display("FAIL ar_grant got %b want 0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ar_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL ar_sel got %0d want 0", sel); else n_pass++;
    req = 4'b1010;
    #1;
    rst = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0010) $display("FAIL ar_first got %b want 0010", grant); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] exp_grant;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      tick();
      exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      n_checks++; if (grant !== exp_grant) $display("FAIL rnd_grant[%0d] got %b want %b", n, grant, exp_grant); else n_pass++;
      n_checks++; if (sel !== 2'(m_last)) $display("FAIL rnd_sel[%0d] got %0d want %0d", n, sel, m_last); else n_pass++;
      n_checks++; if (busy !== (m_owner >= 0)) $display("FAIL rnd_busy[%0d] got %b want %b", n, busy, m_owner >= 0); else n_pass++;
      n_checks++; if (timeout !== m_timeout) $display("FAIL rnd_timeout[%0d] got %b want %b", n, timeout, m_timeout); else n_pass++;
    end
    done = 1'b0;
    req  = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "simulation time limit");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb4_sel.md
# rr_arb4_sel

Four-requester round-robin arbiter that generates the 2-bit select for the downstream 4:1 mux. Each of the four mux inputs belongs to one requester. The arbiter grants exactly one requester at a time and holds the grant until the owner releases it or a hold timeout expires. It drives `sel` so the mux forwards the owner's bit to `dout`.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant may be held; 0 disables the timeout. Legal range 0–255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  4  per-requester request, level-sensitive; bit i means requester i wants ownership.
- `done`  in  1  owner release pulse; applies to the current owner only.
- `grant`  out  4  one-hot grant; all zero when idle.
- `sel`  out  2  index of the current owner; holds the last owner's index while idle; drives the mux `sel`.
- `busy`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold timer.

## Operation
- **States:**
  - IDLE: `grant`=0, `busy`=0.
  - OWN: exactly one `grant` bit set, `busy`=1.
- **IDLE → OWN:** taken at the clock edge where `req`≠0. The winner is the first set `req` bit found searching upward from priority pointer `ptr`, wrapping 3→0.
  - `grant` takes the winner's one-hot value.
  - `sel` takes the winner's index.
  - The hold counter clears to 0.
- **OWN → IDLE:** taken at the first edge where any of these holds:
  - (a) `done`=1;
  - (b) `req[sel]`=0, meaning the owner dropped its request (implicit release);
  - (c) `MAX_HOLD`≠0 and the hold counter equals `MAX_HOLD`-1.
- **On release:**
  - `ptr` becomes `sel`+1 mod 4, so the releasing owner becomes lowest priority.
  - `grant` clears.
  - `sel` is unchanged.
- **Timeout flag:** `timeout` pulses for one cycle only when (c) alone caused the release. If (a) or (b) is also true on that edge, `timeout` stays 0.
- **Hold counter:** increments each cycle in OWN; width is ceil(log2(`MAX_HOLD`+1)), minimum 1 bit. It never wraps, because release occurs at `MAX_HOLD`-1.
- **Ignored inputs:**
  - `done` in IDLE has no effect.
  - `req` bits of non-owners have no effect while in OWN.
- **Output cleanliness:** `grant`, `sel`, `busy` and `timeout` are registered outputs with no combinational paths from inputs.
- **Invariants:**
  - `grant` is zero or one-hot.
  - When `grant`≠0, `grant[sel]`=1.

## Timing
- **Reset values:** `grant`=0, `sel`=0, `busy`=0, `timeout`=0, `ptr`=0, hold counter 0, state IDLE.
- **Reset during OWN:** all outputs clear asynchronously on `rst` assertion, not at the next edge. After `rst` deasserts, the first arbitration uses `ptr`=0.
- **Grant latency:** `req` high before edge N gives `grant` and `sel` valid after edge N, i.e. 1 cycle.
- **Release latency:** a release condition true before edge M gives `grant`=0 after edge M.
- **Dead cycle:** IDLE lasts at least one cycle between owners. The next grant appears after edge M+1 at the earliest, so back-to-back handovers are spaced by 1 idle cycle.
- **Maximum hold:** with `MAX_HOLD`=K>0, the grant lasts at most K cycles.
- **Starvation bound:** with all four requesting continuously and no `done`, each requester receives a grant within 3·(K+1) cycles of the previous owner's release.
- **Stable select:** `sel` changes only on the IDLE→OWN edge, so the mux input is stable for the whole ownership.

## Test plan
- **Reset and single request:** reset, then `req`=0100 → after 1 edge `grant`=0100, `sel`=2, `busy`=1. Then `done` pulse → `grant`=0, `sel` stays 2, `busy`=0.
- **Round-robin rotation:** `req`=1111 held, `done` pulsed 2 cycles after each grant.
  - Required grant order: 0,1,2,3,0.
  - Each grant is separated by exactly 1 idle cycle.
- **Timeout:** `MAX_HOLD`=4, `req`=0001 held, no `done`.
  - `grant`=0001 for exactly 4 cycles.
  - `timeout`=1 for one cycle on release.
  - Re-grant to 0001 after 1 idle cycle, because it is the only requester.
- **Simultaneous release causes:** `done`=1 on the same edge the counter reaches `MAX_HOLD`-1 → release with `timeout`=0. Separately, the owner drops `req` → release on the next edge, and the pointer advances past the owner.
- **Pointer wrap:** owner 3 releases with `req`=1001 pending → next `grant`=0001, `sel`=0.
- **Asynchronous reset mid-grant:** `rst` asserted between edges while `grant`=1000 → `grant`=0, `busy`=0, `sel`=0 before the next edge. After `rst` deasserts with `req`=1010, the first grant is 0010.
